vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator for 640x480 @ 60 Hz VGA. It sits upstream of the pixel colour driver. It divides the 100 MHz system clock down to a 25 MHz pixel enable and keeps horizontal and vertical position counters. From those it produces `currentColumn`, `currentRow`, `video_on` and registered active-low `hsync`/`vsync`. A frame-boundary enable lets software start and park the display cleanly.

## Interface
- `H_ACTIVE`, 640: visible columns
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible rows
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BP`, 33: vertical back porch
- `CLK_DIV`, 4: system clocks per pixel (≥2)

- `clk` in 1: system clock; the block has one clock
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: run request, sampled only at frame boundaries
- `pixel_tick` out 1: one-`clk` pulse every `CLK_DIV` clocks
- `currentColumn` out 10: horizontal position, 0..H_TOTAL-1 (H_TOTAL=800)
- `currentRow` out 10: vertical position, 0..V_TOTAL-1 (V_TOTAL=525)
- `video_on` out 1: high when column < H_ACTIVE and row < V_ACTIVE
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `line_start` out 1: one-`clk` pulse when the column becomes 0
- `frame_start` out 1: one-`clk` pulse when (row, column) becomes (0,0)
- `running` out 1: high in RUN state

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. It runs in all states.
- `pixel_tick` is registered and is high on the cycle following `div==CLK_DIV-2`. Result: exactly one high cycle per `CLK_DIV` clocks.
- State machine has two states, IDLE and RUN.
  - IDLE: counters hold 0; `video_on`=0, `hsync`=`vsync`=1, `running`=0.
  - IDLE→RUN: on a `pixel_tick` cycle with `en`=1. Loads (0,0), `video_on`=1, pulses `frame_start` and `line_start`.
  - RUN→IDLE: on the `pixel_tick` where column=799 and row=524 (frame wrap) and `en`=0. Counters go to 0 and outputs take IDLE values. No `frame_start` pulse.
  - RUN→RUN at frame wrap with `en`=1: column and row go to 0, `frame_start` pulses.
- In RUN, column advances only on `pixel_tick`. On 799 it wraps to 0 and row increments. Row wraps 524→0.
- Column regions, in order:
  - active 0–639
  - front porch 640–655
  - sync 656–751
  - back porch 752–799
- Row regions:
  - active 0–479
  - front porch 480–489
  - sync 490–491
  - back porch 492–524
- `hsync`=0 iff column in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- `vsync`=0 iff row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- All outputs are registered. They are computed from the next counter values, so every output always agrees with `currentColumn`/`currentRow` on the same cycle.
- `en` changes in mid-frame have no effect until the frame wrap.
- Width rules:
  - H_TOTAL and V_TOTAL are sums of the parameters and must be ≤1024.
  - Comparisons are unsigned 10-bit.
  - `div` is ceil(log2(CLK_DIV)) bits.

## Timing
- Reset values:
  - `div`=0, state IDLE, `currentColumn`=0, `currentRow`=0
  - `video_on`=0, `hsync`=1, `vsync`=1
  - `pixel_tick`=0, `line_start`=0, `frame_start`=0, `running`=0
- An `rst` assertion mid-frame forces the reset values immediately (asynchronously). No partial sync pulse continues.
- Latency from `pixel_tick` to the position update: the update occurs on the same `clk` edge that ends the tick cycle. Outputs are visible the following cycle, with `line_start`/`frame_start` high for exactly that one cycle.
- Each position value is held for exactly `CLK_DIV` clocks.
- Line period: 800×CLK_DIV clk. Frame period: 420,000×CLK_DIV clk.
- First `frame_start` after reset release with `en`=1: within CLK_DIV+1 clocks.

## Test plan
- Reset, `en`=1, run 2 frames:
  - `frame_start` interval = 1,680,000 clk.
  - `line_start` interval = 3,200 clk.
  - 525 `line_start` pulses per frame.
- Horizontal sync check:
  - `hsync` low exactly when column ∈ 656..751 (96×4=384 clk per line).
  - `video_on` goes 1→0 between column 639 and 640.
- Vertical sync check:
  - `vsync` low only for rows 490–491, i.e. 2×3,200 clk.
  - `video_on`=0 for every column of rows 480–524.
- Drop `en` at row 100 of frame 1:
  - Frame completes normally.
  - After column 799 / row 524 the block goes IDLE: `running`=0, `hsync`=`vsync`=1, counters 0, no `frame_start`.
  - Raise `en`: the next tick gives (0,0), `video_on`=1, `frame_start`=1.
- Assert `rst` at row 490, column 700 (both syncs low):
  - Same cycle: `hsync`=`vsync`=1, `video_on`=0, counters 0.
  - After release, restart from (0,0).
- Set `CLK_DIV`=2, run 1 frame:
  - `pixel_tick` every 2 clk.
  - Frame = 840,000 clk.
  - Sync windows unchanged in pixel units.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: divides clk to a pixel enable, tracks
// column/row, and emits registered syncs, video_on and line/frame strobes.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pixel_tick,
    output logic [9:0] currentColumn,
    output logic [9:0] currentRow,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div;
    logic [9:0]       col_nxt, row_nxt;
    logic             line_nxt, frame_nxt;
    logic             run_nxt, video_nxt, hsync_nxt, vsync_nxt;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        col_nxt   = currentColumn;
        row_nxt   = currentRow;
        line_nxt  = 1'b0;
        frame_nxt = 1'b0;

        if (pixel_tick) begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_nxt = RUN;
                        col_nxt   = '0;
                        row_nxt   = '0;
                        line_nxt  = 1'b1;
                        frame_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (currentColumn == H_LAST) begin
                        col_nxt = '0;
                        if (currentRow == V_LAST) begin
                            row_nxt = '0;
                            // Parking at the frame wrap is silent: no strobes.
                            if (en) begin
                                line_nxt  = 1'b1;
                                frame_nxt = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            row_nxt  = currentRow + 10'd1;
                            line_nxt = 1'b1;
                        end
                    end else begin
                        col_nxt = currentColumn + 10'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Outputs are derived from the next position so they register in step with it.
        run_nxt   = (state_nxt == RUN);
        video_nxt = run_nxt && (col_nxt < H_ACT) && (row_nxt < V_ACT);
        hsync_nxt = !(run_nxt && (col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST));
        vsync_nxt = !(run_nxt && (row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            div           <= '0;
            pixel_tick    <= 1'b0;
            currentColumn <= '0;
            currentRow    <= '0;
            video_on      <= 1'b0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            running       <= 1'b0;
        end else begin
            div           <= (div == DIV_LAST) ? '0 : div + 1'b1;
            pixel_tick    <= (div == DIV_PRE);
            state         <= state_nxt;
            currentColumn <= col_nxt;
            currentRow    <= row_nxt;
            video_on      <= video_nxt;
            hsync         <= hsync_nxt;
            vsync         <= vsync_nxt;
            line_start    <= line_nxt;
            frame_start   <= frame_nxt;
            running       <= run_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken raster: a frame-position
// model queues the expected outputs each cycle and a monitor compares them.
module tb_vga_sync_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int CLK_DIV  = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int BUDGET   = 2 * FRAME * CLK_DIV + 100;

    typedef struct packed {
        logic       tick;
        logic [9:0] col;
        logic [9:0] row;
        logic       von;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       run;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       pixel_tick;
    logic [9:0] currentColumn;
    logic [9:0] currentRow;
    logic       video_on, hsync, vsync, line_start, frame_start, running;

    int vectors     = 0;
    int miscompares = 0;

    obs_t exp_q[$];

    // Reference model: position is a flat pixel index within the frame.
    int   m_n   = 0;
    int   m_pos = 0;
    logic m_run = 1'b0;
    logic m_tick = 1'b0;
    logic m_ls = 1'b0;
    logic m_fs = 1'b0;

    vga_sync_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pixel_tick(pixel_tick),
        .currentColumn(currentColumn),
        .currentRow(currentRow),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .line_start(line_start),
        .frame_start(frame_start),
        .running(running)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_out();
        obs_t e;
        int   c, r;
        c      = m_pos % H_TOTAL;
        r      = m_pos / H_TOTAL;
        e.tick = m_tick;
        e.col  = 10'(c);
        e.row  = 10'(r);
        e.von  = m_run && (c < H_ACTIVE) && (r < V_ACTIVE);
        e.hs   = !(m_run && (c >= H_ACTIVE + H_FP) && (c < H_ACTIVE + H_FP + H_SYNC));
        e.vs   = !(m_run && (r >= V_ACTIVE + V_FP) && (r < V_ACTIVE + V_FP + V_SYNC));
        e.ls   = m_ls;
        e.fs   = m_fs;
        e.run  = m_run;
        return e;
    endfunction

    function automatic obs_t dut_out();
        obs_t a;
        a.tick = pixel_tick;
        a.col  = currentColumn;
        a.row  = currentRow;
        a.von  = video_on;
        a.hs   = hsync;
        a.vs   = vsync;
        a.ls   = line_start;
        a.fs   = frame_start;
        a.run  = running;
        return a;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got tick=%b col=%0d row=%0d von=%b hs=%b vs=%b ls=%b fs=%b run=%b, want tick=%b col=%0d row=%0d von=%b hs=%b vs=%b ls=%b fs=%b run=%b",
                     name, $time, act.tick, act.col, act.row, act.von, act.hs, act.vs,
                     act.ls, act.fs, act.run, exp.tick, exp.col, exp.row, exp.von,
                     exp.hs, exp.vs, exp.ls, exp.fs, exp.run);
        end
    endtask

    // Model: advances once per clock, resets asynchronously with the DUT.
    initial begin
        logic upd;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_n = 0; m_pos = 0; m_run = 1'b0; m_tick = 1'b0;
                m_ls = 1'b0; m_fs = 1'b0;
                exp_q.delete();
            end else begin
                upd    = m_tick;
                m_n    = m_n + 1;
                m_tick = ((m_n % CLK_DIV) == CLK_DIV - 1);
                m_ls   = 1'b0;
                m_fs   = 1'b0;
                if (upd) begin
                    if (!m_run) begin
                        if (en) begin
                            m_run = 1'b1; m_pos = 0; m_ls = 1'b1; m_fs = 1'b1;
                        end
                    end else if (m_pos == FRAME - 1) begin
                        m_pos = 0;
                        if (en) begin
                            m_ls = 1'b1; m_fs = 1'b1;
                        end else begin
                            m_run = 1'b0;
                        end
                    end else begin
                        m_pos = m_pos + 1;
                        m_ls  = ((m_pos % H_TOTAL) == 0);
                    end
                end
            end
            exp_q.push_back(model_out());
        end
    end

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
    end

    task automatic wait_pos(input int r, input int c);
        int k;
        for (k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (currentRow == 10'(r) && currentColumn == 10'(c)) break;
        end
        if (k == BUDGET) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos: row/col %0d/%0d not reached, got %0d/%0d", r, c,
                     currentRow, currentColumn);
        end
    endtask

    task automatic pulse_reset(input int hold);
        obs_t rv;
        rv = '{tick: 1'b0, col: 10'd0, row: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1,
               ls: 1'b0, fs: 1'b0, run: 1'b0};
        #2 rst = 1'b1;
        #1 check("async_reset", dut_out(), rv);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        #1 rst = 1'b1;
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Two full frames of free running.
        repeat (2 * FRAME * CLK_DIV + 20) @(negedge clk);

        // Drop en mid-frame; the frame must complete, then park.
        wait_pos(2, 0);
        en = 1'b0;
        for (k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (!running) break;
        end
        if (k == BUDGET) begin
            vectors++;
            miscompares++;
            $display("FAIL park: running still %b after budget", running);
        end
        repeat (50) @(negedge clk);
        en = 1'b1;
        repeat (200) @(negedge clk);

        // Reset while both syncs are active.
        wait_pos(V_ACTIVE + V_FP, H_ACTIVE + H_FP + 1);
        pulse_reset(2);
        repeat (FRAME * CLK_DIV + 50) @(negedge clk);

        // Random en toggles and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 1999) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
